// File: rtl/llm_params.sv
// rtl/llm_params.sv - shared widths and request record for the cache request front end
package llm_params;

    localparam int TAG_WIDTH       = 8;
    localparam int SET_INDEX_WIDTH = 4;
    localparam int OFFSET_WIDTH    = 4;
    localparam int CHI_DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH      = TAG_WIDTH + SET_INDEX_WIDTH + OFFSET_WIDTH;

    // One queued request; the output slot uses the same record.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [CHI_DATA_WIDTH-1:0] data;
        logic [7:0]                size;
    } llm_req_t;

endpackage

// File: rtl/llm_req_fifo.sv
// rtl/llm_req_fifo.sv - circular request FIFO of llm_req_t with push/pop/count/full/empty
module llm_req_fifo
    import llm_params::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  llm_req_t                     push_req_i,
    input  logic                         pop_i,
    output llm_req_t                     head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    llm_req_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

endmodule

// File: rtl/llm_req_arb.sv
// rtl/llm_req_arb.sv - request/snoop arbiter feeding the cache core with an optional starvation guard
module llm_req_arb
    import llm_params::*;
#(
    parameter int DEPTH          = 4,
    parameter int MAX_SNP_STREAK = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic [CHI_DATA_WIDTH-1:0]  in_data,
    input  logic [7:0]                 in_size,
    input  logic                       snp_in_valid,
    output logic                       snp_in_ready,
    input  logic [ADDR_WIDTH-1:0]      snp_in_addr,
    output logic [TAG_WIDTH-1:0]       tag,
    output logic [SET_INDEX_WIDTH-1:0] set_index,
    output logic [OFFSET_WIDTH-1:0]    offset,
    output logic [CHI_DATA_WIDTH-1:0]  req_data,
    output logic [7:0]                 req_size,
    output logic                       req_valid,
    output logic                       req_snp,
    input  logic                       req_ready
);

    localparam int CW = $clog2(DEPTH+1);

    llm_req_t              fifo_head;
    llm_req_t              push_req;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty, fifo_has;
    logic                  push, pop;

    logic                  snp_buf_valid_q, snp_buf_valid_d;
    logic [ADDR_WIDTH-1:0] snp_buf_addr_q, snp_buf_addr_d;

    llm_req_t              slot_q, slot_d;
    logic                  req_valid_q, req_valid_d;
    logic                  req_snp_q, req_snp_d;

    logic                  slot_free, starve, grant_snp, grant_req, snp_take;

    assign push_req = '{addr: in_addr, data: in_data, size: in_size};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign fifo_has = !fifo_empty;

    llm_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_req_i (push_req),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Arbitration: a buffered snoop wins unless the guard forces the FIFO head through.
    assign slot_free = !req_valid_q || req_ready;
    assign grant_snp = snp_buf_valid_q && !starve;
    assign grant_req = fifo_has && !grant_snp;
    assign pop       = slot_free && grant_req;
    assign snp_take  = slot_free && grant_snp;

`ifdef LLM_REQ_STARVE_EN
    localparam int SW = $clog2(MAX_SNP_STREAK+1);

    logic [SW-1:0] streak_q, streak_d;

    assign starve = (streak_q == SW'(MAX_SNP_STREAK)) && (fifo_count != '0);

    // Count snoop grants made while a request waits; any request grant or an empty queue resets it.
    always_comb begin
        streak_d = streak_q;
        if (fifo_count == '0) begin
            streak_d = '0;
        end else if (pop) begin
            streak_d = '0;
        end else if (snp_take) begin
            streak_d = streak_q + SW'(1);
        end
    end

    // Streak register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    logic unused_cfg;

    assign starve     = 1'b0;
    assign unused_cfg = (MAX_SNP_STREAK > 0) ^ (|fifo_count);
`endif

    // Snoop buffer and output slot next state.
    always_comb begin
        snp_buf_valid_d = snp_buf_valid_q;
        snp_buf_addr_d  = snp_buf_addr_q;
        slot_d          = slot_q;
        req_valid_d     = req_valid_q;
        req_snp_d       = req_snp_q;

        // Accept and grant cannot coincide: the buffer only accepts while empty.
        if (snp_in_valid && !snp_buf_valid_q) begin
            snp_buf_valid_d = 1'b1;
            snp_buf_addr_d  = snp_in_addr;
        end else if (snp_take) begin
            snp_buf_valid_d = 1'b0;
        end

        if (slot_free) begin
            if (grant_snp) begin
                slot_d      = '{addr: snp_buf_addr_q, data: '0, size: '0};
                req_valid_d = 1'b1;
                req_snp_d   = 1'b1;
            end else if (grant_req) begin
                slot_d      = fifo_head;
                req_valid_d = 1'b1;
                req_snp_d   = 1'b0;
            end else begin
                req_valid_d = 1'b0;
                req_snp_d   = 1'b0;
            end
        end
    end

    // Snoop buffer and output slot registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snp_buf_valid_q <= 1'b0;
            snp_buf_addr_q  <= '0;
            slot_q          <= '0;
            req_valid_q     <= 1'b0;
            req_snp_q       <= 1'b0;
        end else begin
            snp_buf_valid_q <= snp_buf_valid_d;
            snp_buf_addr_q  <= snp_buf_addr_d;
            slot_q          <= slot_d;
            req_valid_q     <= req_valid_d;
            req_snp_q       <= req_snp_d;
        end
    end

    assign snp_in_ready = !snp_buf_valid_q;
    assign req_valid    = req_valid_q;
    assign req_snp      = req_snp_q;
    assign offset       = slot_q.addr[OFFSET_WIDTH-1:0];
    assign set_index    = slot_q.addr[OFFSET_WIDTH +: SET_INDEX_WIDTH];
    assign tag          = slot_q.addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_data     = slot_q.data;
    assign req_size     = slot_q.size;

endmodule

// File: tb/tb_llm_req_arb.sv
// tb/tb_llm_req_arb.sv - directed self-checking bench for llm_req_arb
module tb_llm_req_arb;
    import llm_params::*;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [ADDR_WIDTH-1:0]      in_addr;
    logic [CHI_DATA_WIDTH-1:0]  in_data;
    logic [7:0]                 in_size;
    logic                       snp_in_valid;
    logic                       snp_in_ready;
    logic [ADDR_WIDTH-1:0]      snp_in_addr;
    logic [TAG_WIDTH-1:0]       tag;
    logic [SET_INDEX_WIDTH-1:0] set_index;
    logic [OFFSET_WIDTH-1:0]    offset;
    logic [CHI_DATA_WIDTH-1:0]  req_data;
    logic [7:0]                 req_size;
    logic                       req_valid;
    logic                       req_snp;
    logic                       req_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic                      hs_snp  [$];
    logic [CHI_DATA_WIDTH-1:0] hs_data [$];
    int                        first_req;
    int                        n_req;

    llm_req_arb #(
        .DEPTH          (4),
        .MAX_SNP_STREAK (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_size      (in_size),
        .snp_in_valid (snp_in_valid),
        .snp_in_ready (snp_in_ready),
        .snp_in_addr  (snp_in_addr),
        .tag          (tag),
        .set_index    (set_index),
        .offset       (offset),
        .req_data     (req_data),
        .req_size     (req_size),
        .req_valid    (req_valid),
        .req_snp      (req_snp),
        .req_ready    (req_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] slot_view();
        return {8'h0, tag, set_index, offset, req_data, req_size};
    endfunction

    function automatic logic [63:0] exp_slot(input logic [15:0] a, input logic [31:0] d, input logic [7:0] s);
        return {8'h0, a, d, s};
    endfunction

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_addr      = '0;
        in_data      = '0;
        in_size      = '0;
        snp_in_valid = 1'b0;
        snp_in_addr  = '0;
        req_ready    = 1'b0;

        // Reset state
        tick;
        tick;
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_req_snp", req_snp, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_snp_in_ready", snp_in_ready, 1'b1);
        check("rst_fields", slot_view(), 64'h0);
        rst_n = 1'b1;
        tick;

        // Single read: address split and one-cycle latency
        req_ready = 1'b1;
        in_valid  = 1'b1;
        in_addr   = 16'h1235;
        in_data   = 32'h0;
        in_size   = 8'd0;
        tick;
        in_valid = 1'b0;
        check("rd_not_comb", req_valid, 1'b0);
        tick;
        check("rd_valid", req_valid, 1'b1);
        check("rd_tag", tag, 8'h12);
        check("rd_set", set_index, 4'd3);
        check("rd_off", offset, 4'd5);
        check("rd_snp", req_snp, 1'b0);
        check("rd_data_size", {req_data, req_size}, 40'h0);
        tick;
        check("rd_drained", req_valid, 1'b0);

        // Fill: slot absorbs the first, FIFO fills after the next DEPTH accepts
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_addr  = 16'h1000 + 16'(i) * 16'h0111;
            in_data  = 32'hA0 + 32'(i);
            in_size  = 8'(i + 1);
            tick;
            check($sformatf("fill_in_ready_%0d", i), in_ready, (i != 4));
        end
        in_addr = 16'hDEAD;
        in_data = 32'hDEAD;
        tick;
        in_valid = 1'b0;
        check("full_blocks", in_ready, 1'b0);

        // Stall: slot stable, FIFO untouched
        for (int i = 0; i < 5; i++) begin
            tick;
            check($sformatf("stall_valid_%0d", i), req_valid, 1'b1);
            check($sformatf("stall_slot_%0d", i), slot_view(), exp_slot(16'h1000, 32'hA0, 8'd1));
            check($sformatf("stall_full_%0d", i), in_ready, 1'b0);
        end

        // One accept frees a FIFO entry on the next edge
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0;
        check("pop_in_ready", in_ready, 1'b1);
        check("order_1", slot_view(), exp_slot(16'h1111, 32'hA1, 8'd2));
        req_ready = 1'b1;
        tick;
        check("order_2", slot_view(), exp_slot(16'h1222, 32'hA2, 8'd3));
        tick;
        check("order_3", slot_view(), exp_slot(16'h1333, 32'hA3, 8'd4));
        tick;
        check("order_4", slot_view(), exp_slot(16'h1444, 32'hA4, 8'd5));
        tick;
        check("order_drained", req_valid, 1'b0);

        // Snoop and request pending together: snoop first
        req_ready    = 1'b0;
        in_valid     = 1'b1;
        in_addr      = 16'h2222;
        in_data      = 32'hBB;
        in_size      = 8'd2;
        snp_in_valid = 1'b1;
        snp_in_addr  = 16'h3456;
        tick;
        in_valid     = 1'b0;
        snp_in_valid = 1'b0;
        check("snp_buf_full", snp_in_ready, 1'b0);
        tick;
        check("snp_first_valid", req_valid, 1'b1);
        check("snp_first_flag", req_snp, 1'b1);
        check("snp_first_slot", slot_view(), exp_slot(16'h3456, 32'h0, 8'd0));
        req_ready = 1'b1;
        tick;
        check("req_second_flag", req_snp, 1'b0);
        check("req_second_slot", slot_view(), exp_slot(16'h2222, 32'hBB, 8'd2));
        tick;
        check("snp_req_drained", req_valid, 1'b0);

        // Back-to-back snoops against one queued request
        req_ready    = 1'b0;
        in_valid     = 1'b1;
        in_addr      = 16'h4444;
        in_data      = 32'hCC;
        in_size      = 8'd1;
        snp_in_valid = 1'b1;
        snp_in_addr  = 16'h5550;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        check("streak_setup_snp", {req_valid, req_snp, snp_in_ready}, 3'b110);
        for (int k = 0; k < 12; k++) begin
            req_ready = (k % 2 == 0);
            if (req_valid && req_ready) begin
                hs_snp.push_back(req_snp);
                hs_data.push_back(req_data);
            end
            tick;
        end
        snp_in_valid = 1'b0;
        req_ready    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (req_valid) begin
                hs_snp.push_back(req_snp);
                hs_data.push_back(req_data);
            end
            tick;
        end
        first_req = -1;
        n_req     = 0;
        foreach (hs_snp[i]) begin
            if (!hs_snp[i]) begin
                n_req++;
                if (first_req < 0) begin
                    first_req = i;
                    check("streak_req_data", hs_data[i], 32'hCC);
                end
            end
        end
        check("streak_req_count", n_req, 1);
`ifdef LLM_REQ_STARVE_EN
        check("streak_first_req", first_req, 3);
        check("streak_resume", {hs_snp[4], hs_snp[5]}, 2'b11);
`else
        check("strict_req_late", (first_req >= 6), 1'b1);
`endif
        check("streak_drained", req_valid, 1'b0);

        // Reset with queued entries and a valid slot
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_addr  = 16'h6000 + 16'(i);
            in_data  = 32'hE0 + 32'(i);
            in_size  = 8'd1;
            tick;
        end
        check("pre_rst_valid", req_valid, 1'b1);
        snp_in_valid = 1'b1;
        snp_in_addr  = 16'h7777;
        rst_n        = 1'b0;
        tick;
        check("mid_rst_valid", req_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_snp_ready", snp_in_ready, 1'b1);
        check("mid_rst_fields", slot_view(), 64'h0);
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        snp_in_valid = 1'b0;
        req_ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("post_rst_empty_%0d", i), req_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
